brick_hit_eraser: RTL and testbench
===================================

# brick_hit_eraser

Collision responder for the brick field stored in the 256x18 brick RAM. The brick RAM holds one record per brick: colour in bits [17:15], y in bits [14:8], x in bits [7:0]. A colour of 0 means the brick has been cleared.

Given a ball coordinate, this block computes the brick address and reads that record. On a hit it clears the record and plots the 16x4 brick footprint black to the VGA adapter. It sits between the ball-motion logic, which issues queries, and the shared brick RAM port and VGA plot mux.

## Interface
Parameters:
- RAM_LATENCY, 2, cycles from address stable to ram_q valid (1..3)
- NUM_BRICKS, 40, reset value of bricks_left

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous, active-low reset
- query_valid  in  1  query request
- query_x  in  8  ball x (0..159)
- query_y  in  7  ball y (0..119)
- query_ready  out  1  high only in IDLE
- ram_address  out  8  brick RAM address
- ram_data  out  18  RAM write data (always 0)
- ram_wren  out  1  RAM write enable
- ram_q  in  18  RAM read data
- plot_x  out  8  VGA x
- plot_y  out  7  VGA y
- plot_colour  out  3  VGA colour (always 000)
- plot_en  out  1  VGA plot strobe
- result_valid  out  1  one-cycle result pulse
- result_hit  out  1  query hit a live brick
- result_colour  out  3  colour of the brick hit (0 on miss)
- bricks_left  out  6  live brick count
- all_cleared  out  1  bricks_left == 0

Reset is synchronous, active-low on resetn; clock is clk.

## Operation
**Address decode** (combinational on the accepted query):
- row = y[6:3], col = x[7:4]
- Coordinate is valid iff y[2]==0, row<4, x<160.
- addr = (row<<3) + (row<<1) + col, giving 0..39.

**State machine:**
- IDLE: query_ready=1. On query_valid, latch x/y.
  - Valid coordinate -> ADDR.
  - Invalid coordinate -> DONE with hit=0; no RAM access.
- ADDR: ram_address=addr, held for RAM_LATENCY cycles, then -> CHECK.
- CHECK: sample ram_q and latch the record.
  - ram_q[17:15]!=0 -> CLEAR.
  - Otherwise -> DONE with hit=0.
- CLEAR: ram_wren=1, ram_data=0, ram_address=addr, for exactly one cycle. Decrement bricks_left, saturating at 0. -> ERASE.
- ERASE: 6-bit counter cnt runs 0..63, one pixel per cycle.
  - plot_en=1
  - plot_x = rec_x + cnt[3:0]
  - plot_y = rec_y + cnt[5:4]
  - After cnt==63 -> DONE.
- DONE: result_valid=1 for one cycle, with result_hit/result_colour valid in that same cycle. -> IDLE.

**Other rules:**
- query_valid outside IDLE is ignored; it is not queued.
- ram_wren is high only in CLEAR.
- plot_en is high only in ERASE.

**Reset values:**
- All outputs 0, except query_ready=1 and bricks_left=NUM_BRICKS.
- State IDLE, cnt 0.

**Reset mid-operation:** return to IDLE on the next edge. No write is issued, and a partially erased brick is left as-is.

## Timing
Accept edge is E0.
- Invalid query: result_valid in cycle E0+1.
- Miss: RAM_LATENCY+2 cycles from accept to result_valid.
- Hit: RAM_LATENCY + 1 (CHECK) + 1 (CLEAR) + 64 (ERASE) + 1 (DONE) cycles.
- The next query is accepted the cycle after DONE.
- Plot and RAM outputs are registered from state, with no combinational path from query inputs.
- 8-bit plot_x addition never overflows for valid records (max 144+15=159).

## Configuration
- BRICK_HIT_ERASER_COUNT_EN defined: bricks_left counter and all_cleared are implemented as described.
- Not defined: bricks_left is tied to 0, all_cleared is tied to 0, and no counter logic is generated.

## Test plan
- RAM addr0 = {001,y0,x0}, query (5,2): one write addr 0 data 0; 64 plots covering x 0..15, y 0..3, colour 000; result hit=1, colour=001; bricks_left 39.
- Query (20,5): y[2]=1, so invalid; result_valid at E0+1, hit=0, ram_wren never asserted, plot_en never asserted.
- Repeat query (5,2) after clear: hit=0, no write, result at RAM_LATENCY+2 cycles.
- RAM addr39 = {111,y24,x144}, query (150,25): ram_address 39, plots x 144..159, y 24..27, result_colour=111.
- Toggle query_valid during ERASE: ignored, exactly 64 plots; assert resetn=0 at cnt=30: plot_en=0 and query_ready=1 after the next edge.
- With the macro defined, 40 hit queries over a full field: bricks_left 40->0 and all_cleared=1; a 41st hit attempt misses and the count stays 0.

Source files
------------

// File: rtl/brick_hit_eraser.sv
// brick_hit_eraser: looks up the brick under a ball coordinate, clears a live brick in RAM
// and paints its 16x4 footprint black. Define BRICK_HIT_ERASER_COUNT_EN to get the live-brick counter.
module brick_hit_eraser #(
    parameter int RAM_LATENCY = 2,
    parameter int NUM_BRICKS  = 40
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        query_valid,
    input  logic [7:0]  query_x,
    input  logic [6:0]  query_y,
    output logic        query_ready,
    output logic [7:0]  ram_address,
    output logic [17:0] ram_data,
    output logic        ram_wren,
    input  logic [17:0] ram_q,
    output logic [7:0]  plot_x,
    output logic [6:0]  plot_y,
    output logic [2:0]  plot_colour,
    output logic        plot_en,
    output logic        result_valid,
    output logic        result_hit,
    output logic [2:0]  result_colour,
    output logic [5:0]  bricks_left,
    output logic        all_cleared
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CHECK,
        S_CLEAR,
        S_ERASE,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] addr_r;
    logic [1:0] lat_cnt;
    logic [5:0] cnt;
    logic [2:0] rec_colour;
    logic [6:0] rec_y;
    logic [7:0] rec_x;

    logic [3:0] q_row;
    logic [3:0] q_col;
    logic [7:0] q_addr;
    logic       q_ok;
    logic       unused_y_low;

    // Bricks sit on an 8-row pitch, 4 rows tall, ten per row: row*10 + col.
    assign q_row        = query_y[6:3];
    assign q_col        = query_x[7:4];
    assign q_ok         = ~query_y[2] && (q_row < 4'd4) && (query_x < 8'd160);
    assign q_addr       = {1'b0, q_row, 3'b000} + {3'b000, q_row, 1'b0} + {4'b0000, q_col};
    assign unused_y_low = ^query_y[1:0];

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (query_valid) next_state = q_ok ? S_ADDR : S_DONE;
            S_ADDR:  if (lat_cnt == LAT_LAST) next_state = S_CHECK;
            S_CHECK: next_state = (ram_q[17:15] != 3'd0) ? S_CLEAR : S_DONE;
            S_CLEAR: next_state = S_ERASE;
            S_ERASE: if (cnt == 6'd63) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Query latch, RAM wait counter, record capture and pixel counter.
    // Clearing rec_colour on accept makes an invalid query report colour 0 / no hit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_r     <= 8'd0;
            lat_cnt    <= 2'd0;
            cnt        <= 6'd0;
            rec_colour <= 3'd0;
            rec_y      <= 7'd0;
            rec_x      <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (query_valid) begin
                        addr_r     <= q_addr;
                        lat_cnt    <= 2'd0;
                        rec_colour <= 3'd0;
                    end
                end
                S_ADDR:  lat_cnt <= lat_cnt + 2'd1;
                S_CHECK: begin
                    rec_colour <= ram_q[17:15];
                    rec_y      <= ram_q[14:8];
                    rec_x      <= ram_q[7:0];
                    cnt        <= 6'd0;
                end
                S_ERASE: cnt <= cnt + 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        query_ready   = 1'b0;
        ram_address   = 8'd0;
        ram_wren      = 1'b0;
        plot_x        = 8'd0;
        plot_y        = 7'd0;
        plot_en       = 1'b0;
        result_valid  = 1'b0;
        result_hit    = 1'b0;
        result_colour = 3'd0;
        case (state)
            S_IDLE:  query_ready = 1'b1;
            S_ADDR,
            S_CHECK: ram_address = addr_r;
            S_CLEAR: begin
                ram_address = addr_r;
                ram_wren    = 1'b1;
            end
            S_ERASE: begin
                plot_en = 1'b1;
                plot_x  = rec_x + {4'b0000, cnt[3:0]};
                plot_y  = rec_y + {5'b00000, cnt[5:4]};
            end
            S_DONE: begin
                result_valid  = 1'b1;
                result_hit    = (rec_colour != 3'd0);
                result_colour = rec_colour;
            end
            default: ;
        endcase
    end

    assign ram_data    = 18'd0;
    assign plot_colour = 3'b000;

`ifdef BRICK_HIT_ERASER_COUNT_EN
    logic [5:0] left_r;

    always_ff @(posedge clk) begin
        if (!resetn)
            left_r <= 6'(NUM_BRICKS);
        else if (state == S_CLEAR && left_r != 6'd0)
            left_r <= left_r - 6'd1;
    end

    assign bricks_left = left_r;
    assign all_cleared = (left_r == 6'd0);
`else
    logic [5:0] unused_num_bricks;
    assign unused_num_bricks = 6'(NUM_BRICKS);
    assign bricks_left       = 6'd0;
    assign all_cleared       = 1'b0;
`endif

endmodule

// File: tb/tb_brick_hit_eraser.sv
// Scoreboard bench for brick_hit_eraser: directed queries against a latency-accurate RAM model,
// expected writes/plots/results queued by the driver and checked by an independent monitor.
module tb_brick_hit_eraser;

    localparam int RAM_LATENCY = 2;
    localparam int NUM_BRICKS  = 40;
`ifdef BRICK_HIT_ERASER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        query_valid;
    logic [7:0]  query_x;
    logic [6:0]  query_y;
    logic        query_ready;
    logic [7:0]  ram_address;
    logic [17:0] ram_data;
    logic        ram_wren;
    logic [17:0] ram_q;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        plot_en;
    logic        result_valid;
    logic        result_hit;
    logic [2:0]  result_colour;
    logic [5:0]  bricks_left;
    logic        all_cleared;

    brick_hit_eraser #(
        .RAM_LATENCY (RAM_LATENCY),
        .NUM_BRICKS  (NUM_BRICKS)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .query_valid   (query_valid),
        .query_x       (query_x),
        .query_y       (query_y),
        .query_ready   (query_ready),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .ram_q         (ram_q),
        .plot_x        (plot_x),
        .plot_y        (plot_y),
        .plot_colour   (plot_colour),
        .plot_en       (plot_en),
        .result_valid  (result_valid),
        .result_hit    (result_hit),
        .result_colour (result_colour),
        .bricks_left   (bricks_left),
        .all_cleared   (all_cleared)
    );

    typedef struct {
        logic       hit;
        logic [2:0] colour;
        int         lat;
        logic [5:0] left;
        logic       all_clr;
    } result_t;

    result_t     res_q[$];
    logic [17:0] plot_q[$];
    logic [25:0] wr_q[$];

    int checks     = 0;
    int errors     = 0;
    int model_left = NUM_BRICKS;
    int run_len    = 0;

    logic [17:0] mem [0:255];
    logic [7:0]  a_pipe [0:2];
    logic        load_en   = 1'b0;
    logic [7:0]  load_addr = 8'd0;
    logic [17:0] load_data = 18'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Brick RAM model: ram_q follows the address RAM_LATENCY cycles later.
    always @(posedge clk) begin
        a_pipe[0] <= ram_address;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        if (load_en)
            mem[load_addr] <= load_data;
        else if (ram_wren)
            mem[ram_address] <= ram_data;
    end
    assign ram_q = mem[a_pipe[RAM_LATENCY-1]];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0h expected none", name, act);
    endtask

    // Monitor: pops expectations whenever the DUT writes, plots or reports.
    always @(negedge clk) begin
        logic [25:0] ew;
        logic [17:0] ep;
        result_t     er;
        if (!resetn) begin
            run_len = 0;
        end else begin
            if (!query_ready) run_len++;
            if (ram_wren) begin
                if (wr_q.size() == 0) failNow("unexpected_write", {6'd0, ram_address, ram_data});
                else begin
                    ew = wr_q.pop_front();
                    compare("ram_write", {6'd0, ram_address, ram_data}, {6'd0, ew});
                end
            end
            if (plot_en) begin
                if (plot_q.size() == 0) failNow("unexpected_plot", {14'd0, plot_x, plot_y, plot_colour});
                else begin
                    ep = plot_q.pop_front();
                    compare("plot", {14'd0, plot_x, plot_y, plot_colour}, {14'd0, ep});
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) failNow("unexpected_result", {28'd0, result_hit, result_colour});
                else begin
                    er = res_q.pop_front();
                    compare("result_hit", {31'd0, result_hit}, {31'd0, er.hit});
                    compare("result_colour", {29'd0, result_colour}, {29'd0, er.colour});
                    compare("result_latency", run_len, er.lat);
                    compare("bricks_left", {26'd0, bricks_left}, {26'd0, er.left});
                    compare("all_cleared", {31'd0, all_cleared}, {31'd0, er.all_clr});
                end
                run_len = 0;
            end
        end
    end

    task automatic loadBrick(input logic [7:0] a, input logic [17:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, "_query_ready"}, {31'd0, query_ready}, 32'd1);
        compare({tag, "_ram_wren"}, {31'd0, ram_wren}, 32'd0);
        compare({tag, "_plot_en"}, {31'd0, plot_en}, 32'd0);
        compare({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
        compare({tag, "_ram_address"}, {24'd0, ram_address}, 32'd0);
        compare({tag, "_bricks_left"}, {26'd0, bricks_left}, COUNT_EN ? NUM_BRICKS : 0);
        compare({tag, "_all_cleared"}, {31'd0, all_cleared}, 32'd0);
    endtask

    task automatic waitIdle();
        int i;
        for (i = 0; i < 200 && !query_ready; i++) @(negedge clk);
        if (!query_ready) failNow("idle_timeout", {31'd0, query_ready});
    endtask

    task automatic pushExpect(input logic hit, input logic [2:0] colour, input logic [7:0] addr,
                              input logic [7:0] rx, input logic [6:0] ry, input int lat);
        result_t r;
        if (hit) begin
            wr_q.push_back({addr, 18'd0});
            for (int c = 0; c < 64; c++)
                plot_q.push_back({8'(rx + 8'(c % 16)), 7'(ry + 7'(c / 16)), 3'b000});
            if (model_left > 0) model_left--;
        end
        r.hit     = hit;
        r.colour  = colour;
        r.lat     = lat;
        r.left    = COUNT_EN ? 6'(model_left) : 6'd0;
        r.all_clr = COUNT_EN && (model_left == 0);
        res_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic hit,
                                 input logic [2:0] colour, input logic [7:0] addr,
                                 input logic [7:0] rx, input logic [6:0] ry, input int lat,
                                 input bit toggle);
        int i;
        pushExpect(hit, colour, addr, rx, ry, lat);
        waitIdle();
        query_x     = x;
        query_y     = y;
        query_valid = 1'b1;
        @(negedge clk);
        query_valid = 1'b0;
        if (toggle) begin
            repeat (9) @(negedge clk);
            for (int t = 0; t < 20; t++) begin
                query_valid = ~query_valid;
                query_x     = 8'd5;
                query_y     = 7'd2;
                @(negedge clk);
            end
            query_valid = 1'b0;
        end
        for (i = 0; i < 300 && res_q.size() != 0; i++) @(negedge clk);
        if (res_q.size() != 0) begin
            failNow("result_timeout", res_q.size());
            res_q.delete();
            plot_q.delete();
            wr_q.delete();
        end
        @(negedge clk);
        compare("ready_after_done", {31'd0, query_ready}, 32'd1);
    endtask

    task automatic resetMidErase(input logic [7:0] x, input logic [6:0] y, input logic [7:0] addr,
                                 input logic [7:0] rx, input logic [6:0] ry);
        int plots = 0;
        wr_q.push_back({addr, 18'd0});
        for (int c = 0; c < 64; c++)
            plot_q.push_back({8'(rx + 8'(c % 16)), 7'(ry + 7'(c / 16)), 3'b000});
        waitIdle();
        query_x     = x;
        query_y     = y;
        query_valid = 1'b1;
        @(negedge clk);
        query_valid = 1'b0;
        for (int i = 0; i < 200 && plots < 31; i++) begin
            @(negedge clk);
            if (plot_en) plots++;
        end
        compare("plots_before_reset", plots, 31);
        compare("plot_x_at_cnt30", {24'd0, plot_x}, {24'd0, 8'(rx + 8'd14)});
        resetn = 1'b0;
        @(negedge clk);
        wr_q.delete();
        plot_q.delete();
        res_q.delete();
        model_left = NUM_BRICKS;
        checkOutput("mid_reset");
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] fx;
        logic [6:0] fy;
        logic [2:0] fc;
        resetn      = 1'b0;
        query_valid = 1'b0;
        query_x     = 8'd0;
        query_y     = 7'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset");
        resetn = 1'b1;

        loadBrick(8'd0,  {3'b001, 7'd0,  8'd0});
        loadBrick(8'd39, {3'b111, 7'd24, 8'd144});
        loadBrick(8'd15, {3'b010, 7'd8,  8'd80});
        loadBrick(8'd22, {3'b011, 7'd16, 8'd32});

        $display("[TB] hit on brick 0");
        applyStimulus(8'd5, 7'd2, 1'b1, 3'b001, 8'd0, 8'd0, 7'd0, RAM_LATENCY + 67, 1'b0);
        $display("[TB] invalid coordinate");
        applyStimulus(8'd20, 7'd5, 1'b0, 3'b000, 8'd0, 8'd0, 7'd0, 1, 1'b0);
        $display("[TB] repeat query on cleared brick");
        applyStimulus(8'd5, 7'd2, 1'b0, 3'b000, 8'd0, 8'd0, 7'd0, RAM_LATENCY + 2, 1'b0);
        $display("[TB] hit on brick 39");
        applyStimulus(8'd150, 7'd25, 1'b1, 3'b111, 8'd39, 8'd144, 7'd24, RAM_LATENCY + 67, 1'b0);
        $display("[TB] query_valid toggled during erase");
        applyStimulus(8'd85, 7'd9, 1'b1, 3'b010, 8'd15, 8'd80, 7'd8, RAM_LATENCY + 67, 1'b1);
        $display("[TB] reset during erase");
        resetMidErase(8'd33, 7'd17, 8'd22, 8'd32, 7'd16);

        $display("[TB] full field clear");
        for (int a = 0; a < 40; a++)
            loadBrick(8'(a), {3'((a % 7) + 1), 7'((a / 10) * 8), 8'((a % 10) * 16)});
        for (int a = 0; a < 40; a++) begin
            fx = 8'((a % 10) * 16 + (a % 16));
            fy = 7'((a / 10) * 8 + (a % 4));
            fc = 3'((a % 7) + 1);
            applyStimulus(fx, fy, 1'b1, fc, 8'(a), 8'((a % 10) * 16), 7'((a / 10) * 8),
                          RAM_LATENCY + 67, 1'b0);
        end
        applyStimulus(8'd5, 7'd2, 1'b0, 3'b000, 8'd0, 8'd0, 7'd0, RAM_LATENCY + 2, 1'b0);

        repeat (5) @(negedge clk);
        compare("pending_writes", wr_q.size(), 0);
        compare("pending_plots", plot_q.size(), 0);
        compare("pending_results", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
